// File: rtl/booth_multiplier_ctrl.sv
// booth_multiplier_ctrl
// Sequential radix-2 Booth multiplier, signed WIDTH x WIDTH -> 2*WIDTH.
// Drives an external combinational multiplier_adder every cycle, takes its
// result back on add_out and performs the arithmetic right shift of {A,Q,Q_1}.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start                 operation request, sampled only in IDLE
//   multiplicand (M)      signed operand, captured on accepted start
//   multiplier   (Q)      signed operand, captured on accepted start
//   busy                  high while the iteration loop runs (32 cycles)
//   done                  one-cycle pulse, product valid
//   product               signed result register, held until next completion
//   add_a / add_b         adder operands: accumulator A and multiplicand M
//   add_sel0 / add_sel1   adder op select (combinational): sel1=0 pass a,
//                         sel1=1 & sel0=1 add, sel1=1 & sel0=0 subtract
//   add_out               adder result (combinational from add_a/add_b/sels)

module booth_multiplier_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_a,
    output logic [WIDTH-1:0]     add_b,
    output logic                 add_sel0,
    output logic                 add_sel1,
    input  logic [WIDTH-1:0]     add_out
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    q_q, q_d;
    logic                q1_q, q1_d;
    logic [WIDTH-1:0]    m_q, m_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [PROD_W-1:0]   product_q, product_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                a_msb;
    logic                m_msb;
    logic                r_msb;
    logic                add_ovf;
    logic                sub_ovf;
    logic                shift_sign;
    logic [WIDTH-1:0]    a_shift;
    logic [WIDTH-1:0]    q_shift;
    logic                q1_shift;

    assign add_a   = a_q;
    assign add_b   = m_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

    // Booth pair decode {Q[0],Q_1} -> adder operation, only active in CALC
    always_comb begin
        add_sel0 = 1'b0;
        add_sel1 = 1'b0;
        if (state_q == ST_CALC) begin
            case ({q_q[0], q1_q})
                2'b01: begin
                    add_sel1 = 1'b1;
                    add_sel0 = 1'b1;
                end
                2'b10: begin
                    add_sel1 = 1'b1;
                    add_sel0 = 1'b0;
                end
                default: begin
                    add_sel1 = 1'b0;
                    add_sel0 = 1'b0;
                end
            endcase
        end
    end

    // Shift-in bit is the sign of the exact (WIDTH+1)-bit sum/difference,
    // recovered from the truncated adder result via the overflow flag.
    always_comb begin
        a_msb   = a_q[WIDTH-1];
        m_msb   = m_q[WIDTH-1];
        r_msb   = add_out[WIDTH-1];
        add_ovf = (a_msb == m_msb) && (r_msb != a_msb);
        sub_ovf = (a_msb != m_msb) && (r_msb != a_msb);
        shift_sign = a_msb;
        if (add_sel1) begin
            shift_sign = add_sel0 ? (r_msb ^ add_ovf) : (r_msb ^ sub_ovf);
        end
        a_shift  = {shift_sign, add_out[WIDTH-1:1]};
        q_shift  = {add_out[0], q_q[WIDTH-1:1]};
        q1_shift = q_q[0];
    end

    // Next-state and register-input logic
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        q_d       = q_q;
        q1_d      = q1_q;
        m_d       = m_q;
        count_d   = count_q;
        product_d = product_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    a_d     = '0;
                    q1_d    = 1'b0;
                    count_d = '0;
                    state_d = ST_CALC;
                    busy_d  = 1'b1;
                end
            end
            ST_CALC: begin
                a_d     = a_shift;
                q_d     = q_shift;
                q1_d    = q1_shift;
                count_d = count_q + CNT_W'(1);
                if (count_q == LAST_CNT) begin
                    product_d = {a_shift, q_shift};
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            q_q       <= '0;
            q1_q      <= 1'b0;
            m_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            q_q       <= q_d;
            q1_q      <= q1_d;
            m_q       <= m_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_booth_multiplier_ctrl.sv
// Directed testbench for booth_multiplier_ctrl with a behavioural
// multiplier_adder model closing the add_a/add_b/sel -> add_out loop.

module tb_booth_multiplier_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic        add_sel0;
    logic        add_sel1;
    logic [31:0] add_out;

    int n_cmp;
    int n_bad;

    booth_multiplier_ctrl #(
        .WIDTH (32),
        .CNT_W (6)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_sel0     (add_sel0),
        .add_sel1     (add_sel1),
        .add_out      (add_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // multiplier_adder reference behaviour
    always_comb begin
        if (!add_sel1)     add_out = add_a;
        else if (add_sel0) add_out = add_a + add_b;
        else               add_out = add_a - add_b;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and observe 40 cycles; k = cycles after accept edge
    task automatic run_op(input logic [31:0] m, input logic [31:0] q, input bit inject,
                          output int busy_n, output int done_at, output int done_n,
                          output logic [3:0] s1, output logic [3:0] s0,
                          output logic [63:0] prod_mid);
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        step();
        start   = 1'b0;
        busy_n  = 0;
        done_at = -1;
        done_n  = 0;
        s1 = 4'h0;
        s0 = 4'h0;
        prod_mid = 64'h0;
        for (int k = 0; k < 40; k++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k < 4) begin
                s1[k] = add_sel1;
                s0[k] = add_sel0;
            end
            if (k == 5) prod_mid = product;
            if (inject && k == 10) begin
                start        = 1'b1;
                multiplicand = 32'd9;
                multiplier   = 32'd9;
            end
            if (inject && k == 13) start = 1'b0;
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd7;
        step();
        step();
        start = 1'b0;
        reset = 1'b0;
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (product !== 64'h0) begin n_bad++; $display("FAIL reset_product: got %h expected 0", product); end
        n_cmp++; if ({add_sel1, add_sel0} !== 2'b00) begin n_bad++; $display("FAIL reset_sel: got %b expected 00", {add_sel1, add_sel0}); end
        n_cmp++; if (add_b !== 32'h0) begin n_bad++; $display("FAIL reset_add_b: got %h expected 0", add_b); end
    endtask

    task automatic test_basic();
        int bn, da, dn;
        logic [3:0] s1, s0;
        logic [63:0] pm;
        run_op(32'd3, 32'd5, 1'b0, bn, da, dn, s1, s0, pm);
        n_cmp++; if (bn !== 32) begin n_bad++; $display("FAIL basic_busy_cycles: got %0d expected 32", bn); end
        n_cmp++; if (da !== 32) begin n_bad++; $display("FAIL basic_done_cycle: got %0d expected 32", da); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL basic_done_count: got %0d expected 1", dn); end
        n_cmp++; if (product !== 64'h000000000000000F) begin n_bad++; $display("FAIL basic_product: got %h expected 000000000000000f", product); end
        n_cmp++; if (add_b !== 32'd3) begin n_bad++; $display("FAIL basic_add_b: got %h expected 00000003", add_b); end
    endtask

    task automatic test_sel_pattern();
        int bn, da, dn;
        logic [3:0] s1, s0;
        logic [63:0] pm;
        run_op(32'hFFFFFFF9, 32'd6, 1'b0, bn, da, dn, s1, s0, pm);
        n_cmp++; if (product !== 64'hFFFFFFFFFFFFFFD6) begin n_bad++; $display("FAIL neg_product: got %h expected ffffffffffffffd6", product); end
        n_cmp++; if (s1 !== 4'b1010) begin n_bad++; $display("FAIL neg_sel1_seq: got %b expected 1010", s1); end
        n_cmp++; if (s0 !== 4'b1000) begin n_bad++; $display("FAIL neg_sel0_seq: got %b expected 1000", s0); end
        n_cmp++; if (pm !== 64'h000000000000000F) begin n_bad++; $display("FAIL neg_product_hold: got %h expected 000000000000000f", pm); end
    endtask

    task automatic test_min_neg();
        int bn, da, dn;
        logic [3:0] s1, s0;
        logic [63:0] pm;
        run_op(32'h80000000, 32'h80000000, 1'b0, bn, da, dn, s1, s0, pm);
        n_cmp++; if (product !== 64'h4000000000000000) begin n_bad++; $display("FAIL minneg_product: got %h expected 4000000000000000", product); end
        n_cmp++; if (pm !== 64'hFFFFFFFFFFFFFFD6) begin n_bad++; $display("FAIL minneg_product_hold: got %h expected ffffffffffffffd6", pm); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL minneg_done_count: got %0d expected 1", dn); end
    endtask

    task automatic test_extremes();
        int bn, da, dn;
        logic [3:0] s1, s0;
        logic [63:0] pm;
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, bn, da, dn, s1, s0, pm);
        n_cmp++; if (product !== 64'h0000000000000001) begin n_bad++; $display("FAIL ones_product: got %h expected 0000000000000001", product); end
        run_op(32'h7FFFFFFF, 32'h80000000, 1'b0, bn, da, dn, s1, s0, pm);
        n_cmp++; if (product !== 64'hC000000080000000) begin n_bad++; $display("FAIL maxmin_product: got %h expected c000000080000000", product); end
    endtask

    task automatic test_start_ignored();
        int bn, da, dn;
        logic [3:0] s1, s0;
        logic [63:0] pm;
        run_op(32'd3, 32'd5, 1'b1, bn, da, dn, s1, s0, pm);
        n_cmp++; if (product !== 64'h000000000000000F) begin n_bad++; $display("FAIL ignore_product: got %h expected 000000000000000f", product); end
        n_cmp++; if (dn !== 1) begin n_bad++; $display("FAIL ignore_done_count: got %0d expected 1", dn); end
        n_cmp++; if (bn !== 32) begin n_bad++; $display("FAIL ignore_busy_cycles: got %0d expected 32", bn); end
        n_cmp++; if (da !== 32) begin n_bad++; $display("FAIL ignore_done_cycle: got %0d expected 32", da); end
    endtask

    task automatic test_reset_mid();
        int bn, da, dn;
        logic [3:0] s1, s0;
        logic [63:0] pm;
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        start        = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 10; k++) step();
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b expected 0", done); end
        n_cmp++; if (product !== 64'h0) begin n_bad++; $display("FAIL midrst_product: got %h expected 0", product); end
        n_cmp++; if (add_sel1 !== 1'b0) begin n_bad++; $display("FAIL midrst_sel1: got %b expected 0", add_sel1); end
        n_cmp++; if (add_a !== 32'h0) begin n_bad++; $display("FAIL midrst_add_a: got %h expected 0", add_a); end
        step();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_start_ignored: busy got %b expected 0", busy); end
        run_op(32'd4, 32'd4, 1'b0, bn, da, dn, s1, s0, pm);
        n_cmp++; if (product !== 64'h0000000000000010) begin n_bad++; $display("FAIL midrst_next_product: got %h expected 0000000000000010", product); end
        n_cmp++; if (da !== 32) begin n_bad++; $display("FAIL midrst_next_done_cycle: got %0d expected 32", da); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        start = 1'b0;
        multiplicand = 32'h0;
        multiplier   = 32'h0;
        step();
        test_reset();
        test_basic();
        test_sel_pattern();
        test_min_neg();
        test_extremes();
        test_start_ignored();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
